// File: rtl/clock_ce_gen_pkg.sv
// Shared definitions for the clock-enable generator: default ratio width,
// lock sequencer state type and the standard master-clock ratios.
package clock_ce_gen_pkg;

    localparam int CE_W = 16;

    typedef enum logic [0:0] {
        LK_WARMUP = 1'b0,
        LK_LOCKED = 1'b1
    } lock_state_t;

    typedef struct packed {
        logic [CE_W-1:0] num;
        logic [CE_W-1:0] den;
    } ce_ratio_t;

    // Ratios from a 50 MHz master clock
    localparam ce_ratio_t RATIO_50_TO_32M = '{num: 16'd16, den: 16'd25};
    localparam ce_ratio_t RATIO_50_TO_6M  = '{num: 16'd3,  den: 16'd25};
    localparam ce_ratio_t RATIO_50_TO_4M  = '{num: 16'd2,  den: 16'd25};

endpackage

// File: rtl/clock_ce_gen_if.sv
// Control/status bundle between the clock-enable generator and its consumers.
interface clock_ce_gen_if #(
    parameter int CHANNELS = 2
) ();

    logic                mode;
    logic                hold;
    logic                sync;
    logic [CHANNELS-1:0] ce;
    logic                locked;

    modport master (
        output mode,
        output hold,
        output sync,
        input  ce,
        input  locked
    );

    modport slave (
        input  mode,
        input  hold,
        input  sync,
        output ce,
        output locked
    );

endinterface

// File: rtl/clock_ce_gen_ce_frac_div.sv
// One fractional clock-enable channel: accumulates num per cycle and emits a
// registered pulse each time the accumulator wraps past DEN.
module clock_ce_gen_ce_frac_div
    import clock_ce_gen_pkg::*;
#(
    parameter int           W   = CE_W,
    parameter logic [W-1:0] DEN = W'(25)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic         sync,
    input  logic         hold,
    input  logic [W-1:0] num,
    output logic         ce
);

    logic [W-1:0] acc;
    logic [W:0]   sum;
    logic         wrap;

    // acc < DEN and num <= DEN, so the extra bit is enough to never overflow
    assign sum  = {1'b0, acc} + {1'b0, num};
    assign wrap = (sum >= {1'b0, DEN});

    always_ff @(posedge clock) begin
        if (reset) begin
            acc <= '0;
            ce  <= 1'b0;
        end else if (!enable || sync) begin
            acc <= '0;
            ce  <= 1'b0;
        end else if (hold) begin
            ce  <= 1'b0;
        end else if (wrap) begin
            acc <= W'(sum - {1'b0, DEN});
            ce  <= 1'b1;
        end else begin
            acc <= sum[W-1:0];
            ce  <= 1'b0;
        end
    end

endmodule

// File: rtl/clock_ce_gen.sv
// Multi-channel clock-enable generator with emulated PLL lock warm-up and
// runtime selection between two numerator sets.
//
// state     | meaning
// ----------+------------------------------------------------------------
// LK_WARMUP | counting cycles since reset release; channels held cleared
// LK_LOCKED | warm-up done, locked high, channels free-running
module clock_ce_gen
    import clock_ce_gen_pkg::*;
#(
    parameter int                      CHANNELS    = 2,
    parameter int                      W           = CE_W,
    parameter logic [CHANNELS*W-1:0]   NUM_A       = {16'd7, 16'd14},
    parameter logic [CHANNELS*W-1:0]   NUM_B       = {16'd14, 16'd25},
    parameter logic [CHANNELS*W-1:0]   DEN         = {16'd25, 16'd25},
    parameter int                      LOCK_CYCLES = 1024
) (
    input  logic           clock,
    input  logic           reset,
    clock_ce_gen_if.slave  bus
);

    localparam int               CNT_W     = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);

    lock_state_t         lock_state;
    logic [CNT_W-1:0]    lock_cnt;
    logic                locked;
    logic [CHANNELS-1:0] ce_r;

    always_ff @(posedge clock) begin
        if (reset) begin
            lock_state <= LK_WARMUP;
            lock_cnt   <= '0;
            locked     <= 1'b0;
        end else begin
            case (lock_state)
                LK_WARMUP: begin
                    lock_cnt <= lock_cnt + 1'b1;
                    if (lock_cnt == LOCK_LAST) begin
                        lock_state <= LK_LOCKED;
                        locked     <= 1'b1;
                    end
                end
                LK_LOCKED: begin
                    locked <= 1'b1;
                end
                default: begin
                    lock_state <= LK_WARMUP;
                    lock_cnt   <= '0;
                    locked     <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [W-1:0] num_k;

        // Mode change reaches the accumulator on the very next edge
        assign num_k = bus.mode ? NUM_B[k*W +: W] : NUM_A[k*W +: W];

        clock_ce_gen_ce_frac_div #(
            .W   (W),
            .DEN (DEN[k*W +: W])
        ) u_div (
            .clock  (clock),
            .reset  (reset),
            .enable (locked),
            .sync   (bus.sync),
            .hold   (bus.hold),
            .num    (num_k),
            .ce     (ce_r[k])
        );
    end

    assign bus.ce     = ce_r;
    assign bus.locked = locked;

endmodule

// File: tb/tb_clock_ce_gen.sv
// Self-checking bench for clock_ce_gen: directed scenarios plus a random
// phase, compared cycle by cycle against a running-phase reference model.
module tb_clock_ce_gen;

    localparam int                CH   = 2;
    localparam int                W    = 16;
    localparam int                LOCK = 16;
    localparam logic [CH*W-1:0]   P_NUM_A = {16'd14, 16'd7};
    localparam logic [CH*W-1:0]   P_NUM_B = {16'd25, 16'd0};
    localparam logic [CH*W-1:0]   P_DEN   = {16'd25, 16'd25};

    logic clk   = 1'b0;
    logic reset = 1'b1;

    clock_ce_gen_if #(.CHANNELS(CH)) bus ();

    clock_ce_gen #(
        .CHANNELS    (CH),
        .W           (W),
        .NUM_A       (P_NUM_A),
        .NUM_B       (P_NUM_B),
        .DEN         (P_DEN),
        .LOCK_CYCLES (LOCK)
    ) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: total numerator added since the last clear; a pulse
    // happens whenever that total crosses a multiple of DEN.
    longint  num_a [CH] = '{7, 14};
    longint  num_b [CH] = '{0, 25};
    longint  den_m [CH] = '{25, 25};
    longint  phase [CH];
    int      lock_cnt;
    bit      locked_m;
    bit [CH-1:0] ce_m;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pulses [CH];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            lock_cnt = 0;
            locked_m = 1'b0;
            ce_m     = '0;
            for (int k = 0; k < CH; k++) phase[k] = 0;
        end else if (!locked_m) begin
            lock_cnt++;
            locked_m = (lock_cnt >= LOCK);
            ce_m     = '0;
            for (int k = 0; k < CH; k++) phase[k] = 0;
        end else if (bus.sync) begin
            ce_m = '0;
            for (int k = 0; k < CH; k++) phase[k] = 0;
        end else if (bus.hold) begin
            ce_m = '0;
        end else begin
            for (int k = 0; k < CH; k++) begin
                longint n  = bus.mode ? num_b[k] : num_a[k];
                longint np = phase[k] + n;
                ce_m[k]  = ((np / den_m[k]) != (phase[k] / den_m[k]));
                phase[k] = np;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int k = 0; k < CH; k++) begin
            check($sformatf("ce%0d", k), 64'(bus.ce[k]), 64'(ce_m[k]));
            if (bus.ce[k] === 1'b1) pulses[k]++;
        end
        check("locked", 64'(bus.locked), 64'(locked_m));
    endtask

    task automatic clear_counts();
        for (int k = 0; k < CH; k++) pulses[k] = 0;
    endtask

    initial begin
        int last_p;
        int gap_bad;
        int first0;
        int first1;
        bit ce_seen;

        bus.mode = 1'b0;
        bus.hold = 1'b0;
        bus.sync = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_ce", 64'(bus.ce), 64'd0);
        check("rst_locked", 64'(bus.locked), 64'd0);

        // Warm-up: locked low for 15 visible cycles, high from the 16th edge
        reset = 1'b0;
        clear_counts();
        repeat (LOCK - 1) step();
        check("warmup_locked_low", 64'(bus.locked), 64'd0);
        step();
        check("warmup_locked_high", 64'(bus.locked), 64'd1);
        check("warmup_no_ce", 64'(pulses[0] + pulses[1]), 64'd0);

        // Rate: 250 running cycles of 7/25 and 14/25
        clear_counts();
        last_p  = -1;
        gap_bad = 0;
        for (int i = 0; i < 250; i++) begin
            step();
            if (bus.ce[0] === 1'b1) begin
                if (last_p >= 0 && (i - last_p < 3 || i - last_p > 4)) gap_bad++;
                last_p = i;
            end
        end
        check("rate_ch0_70", 64'(pulses[0]), 64'd70);
        check("rate_ch1_140", 64'(pulses[1]), 64'd140);
        check("rate_ch0_spacing", 64'(gap_bad), 64'd0);

        // Mode switch mid-stream: ch1 to 25/25, ch0 to 0/25
        repeat (7) step();
        bus.mode = 1'b1;
        clear_counts();
        repeat (25) step();
        check("mode_ch1_25", 64'(pulses[1]), 64'd25);
        clear_counts();
        repeat (1000) step();
        check("num0_ch0_none", 64'(pulses[0]), 64'd0);
        check("numden_ch1_all", 64'(pulses[1]), 64'd1000);

        // Hold for 10 cycles then resume; model verifies the unshifted pattern
        bus.mode = 1'b0;
        repeat (11) step();
        bus.hold = 1'b1;
        clear_counts();
        repeat (10) step();
        check("hold_no_ce", 64'(pulses[0] + pulses[1]), 64'd0);
        bus.hold = 1'b0;
        repeat (40) step();

        // Sync together with hold clears phase; first pulses follow ceil(DEN/NUM)
        repeat (2) step();
        bus.hold = 1'b1;
        bus.sync = 1'b1;
        step();
        check("sync_ce", 64'(bus.ce), 64'd0);
        bus.hold = 1'b0;
        bus.sync = 1'b0;
        first0 = 0;
        first1 = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (first0 == 0 && bus.ce[0] === 1'b1) first0 = i;
            if (first1 == 0 && bus.ce[1] === 1'b1) first1 = i;
        end
        check("sync_first_ch0", 64'(first0), 64'd4);
        check("sync_first_ch1", 64'(first1), 64'd2);

        // Randomised control traffic
        for (int i = 0; i < 400; i++) begin
            bus.mode = 1'($urandom_range(0, 1));
            bus.hold = ($urandom_range(0, 5) == 0);
            bus.sync = ($urandom_range(0, 19) == 0);
            step();
        end
        bus.mode = 1'b0;
        bus.hold = 1'b0;
        bus.sync = 1'b0;

        // Reset mid-run while ch1 is pulsing every cycle
        bus.mode = 1'b1;
        repeat (5) step();
        reset = 1'b1;
        step();
        check("midrst_ce", 64'(bus.ce), 64'd0);
        check("midrst_locked", 64'(bus.locked), 64'd0);
        reset = 1'b0;
        clear_counts();
        repeat (LOCK - 1) step();
        check("relock_low", 64'(bus.locked), 64'd0);
        step();
        check("relock_high", 64'(bus.locked), 64'd1);
        check("relock_no_ce", 64'(pulses[0] + pulses[1]), 64'd0);
        ce_seen = 1'b0;
        repeat (3) begin
            step();
            if (bus.ce[1] === 1'b1) ce_seen = 1'b1;
        end
        check("relock_run", 64'(ce_seen), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
